// File: rtl/onewire_cycle_master_if.sv
// Avalon-MM register port plus 1-Wire pad signals of onewire_cycle_master.
// The slave modport is the cycle master's side of the bus; the master
// modport is the bus/pad side that drives it.
interface onewire_cycle_master_if #(
  parameter int OWN = 2
);
  logic            avalon_read;
  logic            avalon_write;
  logic [31:0]     avalon_writedata;
  logic [31:0]     avalon_readdata;
  logic            avalon_interrupt;
  logic [OWN-1:0]  owr_p;
  logic [OWN-1:0]  owr_e;
  logic [OWN-1:0]  owr_i;

  modport slave (
    input  avalon_read, avalon_write, avalon_writedata, owr_i,
    output avalon_readdata, avalon_interrupt, owr_p, owr_e
  );

  modport master (
    output avalon_read, avalon_write, avalon_writedata, owr_i,
    input  avalon_readdata, avalon_interrupt, owr_p, owr_e
  );
endinterface

// File: rtl/onewire_cycle_master.sv
// Bit-level 1-Wire master: reset/presence, write-0, write-1 and read slots
// on one of up to 16 open-drain lines, one cycle per register write.
// Optional feature macro: OWM_OVD_EN (overdrive timing set and ovd bit).
module onewire_cycle_master #(
  parameter int CDR = 24,
  parameter int OWN = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  onewire_cycle_master_if.slave bus
);

  localparam int DIV_W = (CDR > 1) ? $clog2(CDR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_WAIT, S_TAIL} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [9:0]        r_us, w_us_nxt;
  logic [OWN-1:0]    r_sync1, r_sync2;
  logic              r_dat, r_pwr, r_pdrv, r_irq, r_crst, r_cbit;
  logic [3:0]        r_sel;
  logic              w_ovd, w_busy, w_tick, w_accept, w_start;
  logic              w_hit_low, w_hit_smp, w_hit_end, w_cap, w_done;
  logic              w_line, w_sel_ok;
  logic [9:0]        w_t_low, w_t_smp, w_t_end;
  logic              w_unused;

`ifdef OWM_OVD_EN
  logic r_ovd;
  assign w_ovd    = r_ovd;
  assign w_unused = &{1'b0, bus.avalon_writedata[31:12], bus.avalon_writedata[7:5]};
`else
  assign w_ovd    = 1'b0;
  assign w_unused = &{1'b0, bus.avalon_writedata[31:12], bus.avalon_writedata[7:5],
                      bus.avalon_writedata[2]};
`endif

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = bus.avalon_write && !w_busy;
  assign w_start  = w_accept && bus.avalon_writedata[4];
  assign w_sel_ok = ({1'b0, r_sel} < 5'(OWN));
  assign w_tick   = (r_div == DIV_W'(CDR - 1));
  assign w_us_nxt = r_us + 10'd1;

  // Phase boundaries (in us) for the cycle type latched at start
  always_comb begin
    w_t_low = 10'd6;
    w_t_smp = 10'd15;
    w_t_end = 10'd70;
    if (r_crst) begin
      w_t_low = 10'd480;
      w_t_smp = 10'd550;
      w_t_end = 10'd960;
    end else if (!r_cbit) begin
      w_t_low = 10'd60;
    end
`ifdef OWM_OVD_EN
    if (w_ovd) begin
      w_t_low = 10'd1;
      w_t_smp = 10'd2;
      w_t_end = 10'd10;
      if (r_crst) begin
        w_t_low = 10'd48;
        w_t_smp = 10'd56;
        w_t_end = 10'd96;
      end else if (!r_cbit) begin
        w_t_low = 10'd8;
      end
    end
`endif
  end

  // Boundaries are hit on the clock that completes the corresponding us
  assign w_hit_low = w_tick && (w_us_nxt == w_t_low);
  assign w_hit_smp = w_tick && (w_us_nxt == w_t_smp);
  assign w_hit_end = w_tick && (w_us_nxt == w_t_end);
  assign w_cap     = ((r_state == S_LOW) || (r_state == S_WAIT)) && w_hit_smp;
  assign w_done    = (r_state == S_TAIL) && w_hit_end;

  // Synchronized level of the selected line; absent lines read high
  always_comb begin
    w_line = 1'b1;
    for (int unsigned i = 0; i < OWN; i++)
      if (r_sel == 4'(i)) w_line = r_sync2[i];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a sample that falls inside the low phase skips WAIT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start)   w_state_nxt = S_LOW;
      S_LOW:  if (w_hit_low) w_state_nxt = (w_t_smp < w_t_low) ? S_TAIL : S_WAIT;
      S_WAIT: if (w_hit_smp) w_state_nxt = S_TAIL;
      S_TAIL: if (w_hit_end) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Register file, timing counters, synchronizer, sample and interrupt
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_div   <= '0;
      r_us    <= '0;
      r_dat   <= 1'b1;
      r_pwr   <= 1'b0;
      r_pdrv  <= 1'b0;
      r_irq   <= 1'b0;
      r_crst  <= 1'b0;
      r_cbit  <= 1'b0;
      r_sel   <= '0;
`ifdef OWM_OVD_EN
      r_ovd   <= 1'b0;
`endif
    end else begin
      r_sync1 <= bus.owr_i;
      r_sync2 <= r_sync1;

      if (!w_busy) begin
        r_div <= '0;
        r_us  <= '0;
      end else if (w_tick) begin
        r_div <= '0;
        r_us  <= w_us_nxt;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_accept) begin
        r_sel <= bus.avalon_writedata[11:8];
        r_pwr <= bus.avalon_writedata[3];
`ifdef OWM_OVD_EN
        r_ovd <= bus.avalon_writedata[2];
`endif
        if (bus.avalon_writedata[4]) begin
          r_crst <= bus.avalon_writedata[1];
          r_cbit <= bus.avalon_writedata[0];
          r_pdrv <= 1'b0;
        end else begin
          r_pdrv <= bus.avalon_writedata[3];
        end
      end else if (w_done) begin
        r_pdrv <= r_pwr;
      end

      if (w_cap) r_dat <= w_sel_ok ? w_line : 1'b1;

      // Completion wins over a read landing on the same clock
      if (w_done)                          r_irq <= 1'b1;
      else if (bus.avalon_read || w_start) r_irq <= 1'b0;
    end
  end

  // Drive only the selected line
  always_comb begin
    bus.owr_e = '0;
    bus.owr_p = '0;
    for (int unsigned i = 0; i < OWN; i++) begin
      if (r_sel == 4'(i)) begin
        bus.owr_e[i] = (r_state == S_LOW);
        bus.owr_p[i] = r_pdrv;
      end
    end
  end

  assign bus.avalon_readdata  = {20'd0, r_sel, 3'd0, w_busy, r_pwr, w_ovd, 1'b0, r_dat};
  assign bus.avalon_interrupt = r_irq;

endmodule

// File: tb/tb_onewire_cycle_master.sv
// Directed plus randomized bench for onewire_cycle_master with a pad/slave
// model and a table-driven reference for timing and sampled values.
module tb_onewire_cycle_master;
  localparam int CDR = 24;
  localparam int OWN = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  onewire_cycle_master_if #(.OWN(OWN)) bus ();

  onewire_cycle_master #(.CDR(CDR), .OWN(OWN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tcount = 0;
  always @(posedge clk) tcount <= tcount + 1;

  // Open-drain line model: pulled up unless master or slave pulls low
  int   t0 = 0;
  logic sl_en = 1'b0;
  int   sl_line = 0, sl_a = 0, sl_b = 0;
  logic [OWN-1:0] pad;
  always_comb begin
    pad = '1;
    for (int i = 0; i < OWN; i++) begin
      if (bus.owr_e[i] && !bus.owr_p[i]) pad[i] = 1'b0;
      if (sl_en && sl_line == i && (tcount - t0) >= sl_a * CDR && (tcount - t0) < sl_b * CDR)
        pad[i] = 1'b0;
    end
  end
  assign bus.owr_i = pad;

  int ntests = 0;
  int nfail  = 0;

`ifdef OWM_OVD_EN
  localparam bit OVD_BUILT = 1'b1;
`else
  localparam bit OVD_BUILT = 1'b0;
`endif

  int T_N [3][3] = '{'{480, 550, 960}, '{60, 15, 70}, '{6, 15, 70}};
  int T_O [3][3] = '{'{48, 56, 96},    '{8, 2, 10},   '{1, 2, 10}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timing(input bit rst, input bit b, input bit ovd,
                        output int lo, output int sm, output int en);
    int k;
    k = rst ? 0 : (b ? 2 : 1);
    if (ovd && OVD_BUILT) begin lo = T_O[k][0]; sm = T_O[k][1]; en = T_O[k][2]; end
    else                  begin lo = T_N[k][0]; sm = T_N[k][1]; en = T_N[k][2]; end
  endtask

  // Line level just before the sample instant (half-us resolution)
  function automatic bit exp_dat(input int sel, input int lo, input int sm,
                                 input bit slv, input int sa, input int sb);
    int  t2;
    bit  pulled;
    if (sel >= OWN) return 1'b1;
    t2 = 2 * sm - 1;
    pulled = (t2 < 2 * lo) || (slv && t2 >= 2 * sa && t2 < 2 * sb);
    return !pulled;
  endfunction

  task automatic reg_write(input logic [31:0] d);
    @(negedge clk);
    bus.avalon_write = 1'b1;
    bus.avalon_writedata = d;
    @(negedge clk);
    bus.avalon_write = 1'b0;
  endtask

  task automatic reg_read_clear();
    @(negedge clk);
    bus.avalon_read = 1'b1;
    @(negedge clk);
    bus.avalon_read = 1'b0;
  endtask

  // One complete cycle, measured and checked against the reference
  task automatic run_cycle(input string tag, input int sel, input bit rst, input bit b,
                           input bit ovd, input bit pwr, input bit slv,
                           input int sa, input int sb, input bit clr);
    int lo, sm, en, n_e, n_busy, n_other;
    logic [OWN-1:0] msk;
    logic [31:0] exp_stat;
    bit d, ovde;
    timing(rst, b, ovd, lo, sm, en);
    ovde = ovd && OVD_BUILT;
    d = exp_dat(sel, lo, sm, slv, sa, sb);
    msk = '0;
    if (sel < OWN) msk[sel] = 1'b1;
    @(negedge clk);
    bus.avalon_write = 1'b1;
    bus.avalon_writedata = {20'd0, 4'(sel), 3'd0, 1'b1, pwr, ovd, rst, b};
    @(negedge clk);
    bus.avalon_write = 1'b0;
    t0 = tcount;
    sl_line = sel; sl_a = sa; sl_b = sb; sl_en = slv;
    n_e = 0; n_busy = 0; n_other = 0;
    while (bus.avalon_readdata[4] === 1'b1 && n_busy < 30000) begin
      if ((bus.owr_e & msk) != '0) n_e++;
      if ((bus.owr_e & ~msk) != '0 || bus.owr_p != '0) n_other++;
      n_busy++;
      @(negedge clk);
    end
    sl_en = 1'b0;
    exp_stat = {20'd0, 4'(sel), 3'd0, 1'b0, pwr, ovde, 1'b0, d};
    check({tag, "_len"},   32'(n_busy), 32'(en * CDR));
    check({tag, "_low"},   32'(n_e), 32'((sel < OWN) ? lo * CDR : 0));
    check({tag, "_other"}, 32'(n_other), 32'd0);
    check({tag, "_stat"},  bus.avalon_readdata, exp_stat);
    check({tag, "_irq"},   32'(bus.avalon_interrupt), 32'd1);
    check({tag, "_p"},     32'(bus.owr_p), pwr ? 32'(msk) : 32'd0);
    if (clr) begin
      reg_read_clear();
      check({tag, "_irqclr"}, 32'(bus.avalon_interrupt), 32'd0);
    end
  endtask

  initial begin
    int n, s, b, c, pw;
    bus.avalon_read = 1'b0;
    bus.avalon_write = 1'b0;
    bus.avalon_writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_stat", bus.avalon_readdata, 32'h1);
    check("rst_irq",  32'(bus.avalon_interrupt), 32'd0);
    check("rst_e",    32'(bus.owr_e), 32'd0);
    check("rst_p",    32'(bus.owr_p), 32'd0);

    // Reset/presence with slave pulling 500..620 us
    run_cycle("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 500, 620, 1'b1);
    // Write-0 then write-1 on line 1, no slave
    run_cycle("wr0", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    run_cycle("wr1", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    // Read slots: slave holds low 0..30 us, then idle
    run_cycle("rd_lo", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 30, 1'b1);
    run_cycle("rd_hi", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    // Selector beyond the implemented lines
    run_cycle("sel_oob", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    // Overdrive bit (normal timing when the feature is not built)
    run_cycle("ovd_rd", 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 30, 1'b1);
`ifdef OWM_OVD_EN
    run_cycle("ovd_rst", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 50, 60, 1'b1);
`endif

    // Strong pull-up after a write-1 cycle
    run_cycle("pwr", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    reg_write(32'h0000_0019);              // write-1, pwr=1, sel=0
    check("pwr_low_p", 32'(bus.owr_p), 32'd0);
    check("pwr_low_e", 32'(bus.owr_e), 32'd1);
    reg_write(32'h0000_0100);              // sel=1, pwr=0, cyc=0 while busy
    n = 0;
    while (bus.avalon_readdata[4] === 1'b1 && n < 5000) begin n++; @(negedge clk); end
    check("busy_ign_stat", bus.avalon_readdata, 32'h0000_0009);
    check("busy_ign_p",    32'(bus.owr_p), 32'd1);
    // Read and write on the same clock while idle
    @(negedge clk);
    bus.avalon_read = 1'b1;
    bus.avalon_write = 1'b1;
    bus.avalon_writedata = 32'h0000_0000;  // pwr=0, cyc=0, sel=0
    check("rw_pre", bus.avalon_readdata, 32'h0000_0009);
    @(negedge clk);
    bus.avalon_read = 1'b0;
    bus.avalon_write = 1'b0;
    check("rw_irq", 32'(bus.avalon_interrupt), 32'd0);
    check("pwr_drop", 32'(bus.owr_p), 32'd0);
    check("rw_stat", bus.avalon_readdata, 32'h0000_0001);

    // Randomized short slots
    for (int k = 0; k < 8; k++) begin
      s  = int'($urandom_range(0, 3));
      b  = int'($urandom_range(0, 1));
      c  = int'($urandom_range(0, 2));
      pw = int'($urandom_range(0, 1));
      run_cycle($sformatf("rnd%0d", k), s, 1'b0, b[0], 1'b0, pw[0], c != 0,
                (c == 2) ? 20 : 0, (c == 2) ? 40 : 30, 1'b1);
    end
    reg_write(32'h0000_0000);

    // Reset asserted 300 us into a reset cycle
    reg_write(32'h0000_0012);
    repeat (300 * CDR) @(negedge clk);
    check("abort_pre_e", 32'(bus.owr_e), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_e",    32'(bus.owr_e), 32'd0);
    check("abort_irq",  32'(bus.avalon_interrupt), 32'd0);
    check("abort_stat", bus.avalon_readdata, 32'h1);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_late_irq",  32'(bus.avalon_interrupt), 32'd0);
    check("abort_late_stat", bus.avalon_readdata, 32'h1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/onewire_cycle_master.md
# onewire_cycle_master

Bit-level 1-Wire master that performs reset/presence, write-0, write-1 and read-slot cycles on one of up to 16 open-drain 1-Wire lines. It sits between the Nios II Avalon-MM bus inside `soc` and the board pad logic. It produces per-line `owr_p`/`owr_e` drive pairs and consumes the returned line levels on `owr_i`. Software issues one cycle per register write and collects the sampled bit on completion, by polling or by interrupt.

## Interface
- `CDR`, default 24: clock cycles per 1 us timing tick (24 MHz system clock); legal range ≥1.
- `OWN`, default 2: number of 1-Wire lines; legal range 1..16.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `avalon_read`  in  1  register read strobe.
- `avalon_write`  in  1  register write strobe.
- `avalon_writedata`  in  32  write data.
- `avalon_readdata`  out  32  status word; zero-wait, combinational from registers.
- `avalon_interrupt`  out  1  cycle-complete interrupt, level.
- `owr_p`  out  OWN  per-line drive-high (strong pull-up).
- `owr_e`  out  OWN  per-line drive enable; `e=1, p=0` pulls the line low.
- `owr_i`  in  OWN  per-line pad level, asynchronous.

## Operation
- Single register. Write fields:
  - [0] `dat`: bit to write; 1 selects a write-1 or read slot.
  - [1] `rst`: 1 selects a reset/presence cycle and ignores `dat`.
  - [2] `ovd`: overdrive timing.
  - [3] `pwr`: strong pull-up.
  - [4] `cyc`: start a cycle.
  - [11:8] `sel`: line index.
- Read fields:
  - [0] `dat`: last sampled level. After a reset cycle, 0 means presence detected.
  - [2] `ovd`.
  - [3] `pwr`.
  - [4] `busy`.
  - [11:8] `sel`.
  - All other bits read 0.
- Write while idle:
  - Latch `ovd`, `pwr` and `sel`.
  - If `cyc=1`, clear `pwr` output drive and start a cycle.
  - If `cyc=0`, apply `pwr` immediately: `owr_p[sel]=pwr`.
- Write while `busy=1`: ignored entirely.
- `owr_i` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- State machine:
  - IDLE: on accepted write with `cyc=1`, go to LOW.
  - LOW: `owr_e[sel]=1`, `owr_p=0`. Go to WAIT when the tick count reaches the low time.
  - WAIT: line released. Go to TAIL when the count reaches the sample time; capture `dat` at that clock.
  - TAIL: go to IDLE when the count reaches the end time. Set `avalon_interrupt`; if `pwr=1`, assert `owr_p[sel]`.
- Normal timing (us), as low / sample / end:
  - reset: 480 / 550 / 960
  - write-0: 60 / 15 / 70
  - write-1 and read: 6 / 15 / 70
- For write-0, the sample falls inside LOW. The captured value is the line level, normally 0. WAIT is skipped and the state goes LOW→TAIL.
- Overdrive timing (us), as low / sample / end:
  - reset: 48 / 56 / 96
  - write-0: 8 / 2 / 10
  - write-1 and read: 1 / 2 / 10
- Any read clears `avalon_interrupt` on the following clock. A new accepted cycle start also clears it.
- `sel ≥ OWN`: the cycle runs with full timing, drives no line, and samples `dat=1`.
- Only line `sel` is ever driven. All other `owr_e`/`owr_p` bits stay 0.

## Timing
- Reset values:
  - `owr_e=0`, `owr_p=0`, `avalon_interrupt=0`.
  - state IDLE; `busy=0`, `dat=1`, `ovd=0`, `pwr=0`, `sel=0`.
  - Synchronizer flops reset to 1.
- Write accepted at clock edge N:
  - At N+1, `busy=1`, `owr_e[sel]=1`, and the tick divider and microsecond counter restart at 0.
  - Low phase lasts exactly low×CDR clocks.
  - Sample is taken at N+1+sample×CDR from the synchronized input, which is 2 clocks behind the pad.
  - At N+1+end×CDR, `busy=0` and `avalon_interrupt=1`. The new `dat` is readable on that same clock.
- Microsecond counter is 10 bits wide and never wraps, because the maximum end value is 960.
- Read and write on the same clock while idle: the read returns pre-write status, and the interrupt is cleared.
- `reset_n` low mid-cycle: on the next edge all outputs return to reset values, the line is released, and no interrupt is raised.

## Configuration
- `OWM_OVD_EN` defined: the overdrive timing set and the `ovd` bit are implemented.
- `OWM_OVD_EN` undefined:
  - `ovd` write data is ignored and reads back 0.
  - Only normal timing is built, and the timing comparators shrink accordingly.

## Test plan
- Reset cycle, `sel=0`, model pulls `owr_i[0]` low over 500–620 us:
  - `owr_e[0]` high for exactly 11520 clocks.
  - `busy` drops after 23040 clocks.
  - `dat=0` and interrupt set.
- Write-0 then write-1 on `sel=1`, no slave:
  - `owr_e[1]` low pulse widths are 1440 and 144 clocks.
  - Each cycle lasts 1680 clocks.
  - `owr_e[0]` stays 0 throughout.
- Read slot, slave holds line low 0–30 us: `dat=0`. Slave idle: `dat=1`.
- `pwr=1` with a write-1 cycle:
  - `owr_p[0]=1` from the cycle-end clock.
  - A following write with `cyc=0, pwr=0` drops it the next clock.
  - A write during `busy` is ignored.
- Overdrive (`OWM_OVD_EN`) reset cycle: low 1152 clocks, end at 2304 clocks.
- `reset_n` asserted at 300 us into a reset cycle:
  - `owr_e=0` next clock.
  - No interrupt.
  - Status reads 0x00000001.
